// File: rtl/adder_sum_stage_pkg.sv
// Shared constants and state encoding for the registered sum stage of the prefix adder.
package adder_sum_stage_pkg;

  localparam int unsigned LEN_DATA  = 32;
  // carry, overflow, zero, negative stored alongside the sum
  localparam int unsigned FLAG_BITS = 4;

  typedef enum logic [1:0] {
    AddSumEmpty = 2'd0,
    AddSumBusy  = 2'd1,
    AddSumFull  = 2'd2
  } add_sum_state_e;

endpackage

// File: rtl/adder_sum_cell.sv
// Combinational carry, sum and NZCV-style flag computation from full-span group G/P.
module adder_sum_cell #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_generate,
  input  logic [WIDTH-1:0] i_propogate,
  input  logic [WIDTH-1:0] i_bit_prop,
  input  logic             i_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;

  // Group terms span [i:0], so each carry needs only the adder carry-in.
  assign w_c   = {i_generate | (i_propogate & {WIDTH{i_carry}}), i_carry};
  assign w_sum = i_bit_prop ^ w_c[WIDTH-1:0];

  assign o_sum      = w_sum;
  assign o_carry    = w_c[WIDTH];
  assign o_overflow = w_c[WIDTH] ^ w_c[WIDTH-1];
  assign o_zero     = ~|w_sum;
  assign o_negative = w_sum[WIDTH-1];

endmodule

// File: rtl/adder_sum_stage.sv
// Final registered adder stage: computes sum/flags and holds them in a 2-entry skid buffer.
module adder_sum_stage
  import adder_sum_stage_pkg::*;
#(
  parameter int unsigned WIDTH = LEN_DATA
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_generate,
  input  logic [WIDTH-1:0] i_propogate,
  input  logic [WIDTH-1:0] i_bit_prop,
  input  logic             i_carry,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative
);

  localparam int unsigned ResW = WIDTH + FLAG_BITS;

  add_sum_state_e  r_state, w_state_d;
  logic [ResW-1:0] r_main, r_skid, w_res;
  logic [WIDTH-1:0] w_sum;
  logic w_carry, w_overflow, w_zero, w_negative;
  logic w_accept, w_deliver, w_load_main_in, w_load_main_skid, w_load_skid;

  adder_sum_cell #(
    .WIDTH(WIDTH)
  ) u_cell (
    .i_generate (i_generate),
    .i_propogate(i_propogate),
    .i_bit_prop (i_bit_prop),
    .i_carry    (i_carry),
    .o_sum      (w_sum),
    .o_carry    (w_carry),
    .o_overflow (w_overflow),
    .o_zero     (w_zero),
    .o_negative (w_negative)
  );

  assign w_res = {w_sum, w_carry, w_overflow, w_zero, w_negative};

  // Gating valid with reset keeps a beat from being taken in the reset cycle.
  assign o_in_ready  = !i_rst && (r_state != AddSumFull);
  assign o_out_valid = !i_rst && (r_state != AddSumEmpty);
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_deliver   = o_out_valid && i_out_ready;

  always_comb begin
    w_state_d        = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      AddSumEmpty: begin
        if (w_accept) begin
          w_state_d      = AddSumBusy;
          w_load_main_in = 1'b1;
        end
      end
      AddSumBusy: begin
        if (w_accept && !w_deliver) begin
          w_state_d   = AddSumFull;
          w_load_skid = 1'b1;
        end else if (w_accept && w_deliver) begin
          w_load_main_in = 1'b1;
        end else if (w_deliver) begin
          w_state_d = AddSumEmpty;
        end
      end
      AddSumFull: begin
        if (w_deliver) begin
          w_state_d        = AddSumBusy;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_d = AddSumEmpty;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= AddSumEmpty;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load_main_in) begin
        r_main <= w_res;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_res;
      end
    end
  end

  assign {o_sum, o_carry, o_overflow, o_zero, o_negative} = r_main;

endmodule
